// File: rtl/mixed_to_analog_assembler.sv
// Rebuilds NUM_CH analog register words from a serial byte stream, LSB byte first.
// The last byte of each word carries only the top word bits; any other set bits flag pad_err.
module mixed_to_analog_assembler #(
  parameter int unsigned WORD_W         = 50,
  parameter int unsigned NUM_CH         = 8,
  parameter int unsigned BYTES_PER_WORD = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  output logic [NUM_CH*WORD_W-1:0]   ch_out,
  output logic [NUM_CH-1:0]          ch_update,
  output logic                       frame_done,
  output logic                       busy,
  output logic                       pad_err
);

  localparam int unsigned ShadowW  = (BYTES_PER_WORD - 1) * 8;
  localparam int unsigned TopW     = WORD_W - ShadowW;
  localparam int unsigned ByteIdxW = $clog2(BYTES_PER_WORD);
  localparam int unsigned ChIdxW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(BYTES_PER_WORD - 1);
  localparam logic [ChIdxW-1:0]   LastCh   = ChIdxW'(NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e                     state_q, state_d;
  logic [ByteIdxW-1:0]        byte_idx_q, byte_idx_d;
  logic [ChIdxW-1:0]          ch_idx_q, ch_idx_d;
  logic [ShadowW-1:0]         shadow_q, shadow_d;
  logic [NUM_CH*WORD_W-1:0]   ch_out_q, ch_out_d;
  logic [NUM_CH-1:0]          ch_update_q, ch_update_d;
  logic                       pad_err_q, pad_err_d;

  logic accept, last_byte, last_ch, commit;

  assign accept    = byte_valid && byte_ready;
  assign last_byte = (byte_idx_q == LastByte);
  assign last_ch   = (ch_idx_q == LastCh);
  assign commit    = accept && last_byte;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (frame_start) state_d = StCollect;
      StCollect: if (commit && last_ch) state_d = StDone;
      StDone:    state_d = frame_start ? StCollect : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    byte_ready = (state_q == StCollect) && !frame_start;
    busy       = (state_q != StIdle);
    frame_done = (state_q == StDone);
  end

  // Datapath next state; frame_start outranks any byte since byte_ready is low then
  always_comb begin
    byte_idx_d  = byte_idx_q;
    ch_idx_d    = ch_idx_q;
    shadow_d    = shadow_q;
    ch_out_d    = ch_out_q;
    ch_update_d = '0;
    pad_err_d   = pad_err_q;
    if (frame_start) begin
      byte_idx_d = '0;
      ch_idx_d   = '0;
      shadow_d   = '0;
      pad_err_d  = 1'b0;
    end else if (accept) begin
      if (last_byte) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (ch_idx_q == ChIdxW'(c)) begin
            ch_out_d[c*WORD_W +: WORD_W] = {byte_in[TopW-1:0], shadow_q};
            ch_update_d[c]               = 1'b1;
          end
        end
        if (|byte_in[7:TopW]) pad_err_d = 1'b1;
        shadow_d   = '0;
        byte_idx_d = '0;
        ch_idx_d   = last_ch ? '0 : ch_idx_q + ChIdxW'(1);
      end else begin
        for (int unsigned b = 0; b < BYTES_PER_WORD - 1; b++) begin
          if (byte_idx_q == ByteIdxW'(b)) shadow_d[8*b +: 8] = byte_in;
        end
        byte_idx_d = byte_idx_q + ByteIdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q  <= '0;
      ch_idx_q    <= '0;
      shadow_q    <= '0;
      ch_out_q    <= '0;
      ch_update_q <= '0;
      pad_err_q   <= 1'b0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      ch_idx_q    <= ch_idx_d;
      shadow_q    <= shadow_d;
      ch_out_q    <= ch_out_d;
      ch_update_q <= ch_update_d;
      pad_err_q   <= pad_err_d;
    end
  end

  assign ch_out    = ch_out_q;
  assign ch_update = ch_update_q;
  assign pad_err   = pad_err_q;

endmodule

// File: tb/tb_mixed_to_analog_assembler.sv
// Directed bench for mixed_to_analog_assembler: full, gapped, pad-error, restart,
// async-reset and idle-byte scenarios, each checked against hand-computed words.
module tb_mixed_to_analog_assembler;

  localparam int unsigned WORD_W = 50;
  localparam int unsigned NUM_CH = 8;

  logic                     clk;
  logic                     rst;
  logic                     frame_start;
  logic [7:0]               byte_in;
  logic                     byte_valid;
  logic                     byte_ready;
  logic [NUM_CH*WORD_W-1:0] ch_out;
  logic [NUM_CH-1:0]        ch_update;
  logic                     frame_done;
  logic                     busy;
  logic                     pad_err;

  int n_cmp;
  int n_fail;

  mixed_to_analog_assembler #(
    .WORD_W        (WORD_W),
    .NUM_CH        (NUM_CH),
    .BYTES_PER_WORD(7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .ch_out     (ch_out),
    .ch_update  (ch_update),
    .frame_done (frame_done),
    .busy       (busy),
    .pad_err    (pad_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] get_ch(input int c);
    return ch_out[c*WORD_W +: WORD_W];
  endfunction

  // mode 0: plan pattern; mode 1: all 8'h55 with last byte 8'h01
  function automatic logic [7:0] get_byte(input int mode, input int c, input int k,
                                          input int pad_ch, input logic [7:0] pad_val);
    if (c == pad_ch && k == 6) return pad_val;
    if (mode == 1) return (k == 6) ? 8'h01 : 8'h55;
    if (c == 0) begin
      case (k)
        0:       return 8'hAB;
        1:       return 8'h89;
        2:       return 8'h67;
        3:       return 8'h45;
        4:       return 8'h23;
        5:       return 8'h01;
        default: return 8'h03;
      endcase
    end
    return (k == 6) ? 8'h02 : 8'(8'h10 + c);
  endfunction

  function automatic logic [WORD_W-1:0] exp_word(input int mode, input int c);
    logic [7:0] b;
    if (mode == 1) return 50'h1_5555_5555_5555;
    if (c == 0) return 50'h3_0123_4567_89AB;
    b = 8'(8'h10 + c);
    return {2'b10, {6{b}}};
  endfunction

  task automatic run_frame(input int mode, input bit gapped, input bit do_start,
                           input int pad_ch, input logic [7:0] pad_val);
    logic [NUM_CH-1:0] exp_upd;
    bit                exp_pad;
    exp_pad = 1'b0;
    if (do_start) begin
      frame_start = 1'b1;
      byte_valid  = 1'b0;
      @(negedge clk);
      frame_start = 1'b0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < 7; k++) begin
        byte_in    = get_byte(mode, c, k, pad_ch, pad_val);
        byte_valid = 1'b1;
        @(negedge clk);
        exp_upd = '0;
        if (k == 6) exp_upd[c] = 1'b1;
        chk("ch_update", 64'(ch_update), 64'(exp_upd));
        if (k == 6) begin
          if (c == pad_ch && pad_val[7:2] != 6'd0) exp_pad = 1'b1;
          chk("ch_word", 64'(get_ch(c)), 64'(exp_word(mode, c)));
          chk("pad_err", 64'(pad_err), 64'(exp_pad));
          chk("frame_done", 64'(frame_done), 64'(c == NUM_CH - 1));
        end
        if (gapped && !(c == NUM_CH - 1 && k == 6)) begin
          byte_valid = 1'b0;
          byte_in    = 8'hEE;
          @(negedge clk);
          chk("gap_update", 64'(ch_update), 64'd0);
          chk("gap_done", 64'(frame_done), 64'd0);
        end
      end
    end
    byte_valid = 1'b0;
    @(negedge clk);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_done", 64'(frame_done), 64'd0);
    chk("post_pad", 64'(pad_err), 64'(exp_pad));
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    frame_start = 1'b0;
    byte_in     = 8'h00;
    byte_valid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ch_out", 64'(|ch_out), 64'd0);
    chk("rst_update", 64'(ch_update), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pad", 64'(pad_err), 64'd0);
    chk("rst_ready", 64'(byte_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back frame
    run_frame(0, 1'b0, 1'b1, -1, 8'h00);
    chk("b2b_ch0", 64'(get_ch(0)), 64'h3_0123_4567_89AB);
    chk("b2b_ch1", 64'(get_ch(1)), 64'h2_1111_1111_1111);

    // Bytes offered in IDLE are ignored
    byte_in    = 8'h77;
    byte_valid = 1'b1;
    #1;
    chk("idle_ready", 64'(byte_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_update", 64'(ch_update), 64'd0);
      chk("idle_ch0", 64'(get_ch(0)), 64'h3_0123_4567_89AB);
    end
    byte_valid = 1'b0;

    // Mid-frame restart after 10 bytes of 8'h20..8'h29
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      byte_in    = 8'(8'h20 + i);
      byte_valid = 1'b1;
      @(negedge clk);
      chk("pre_update", 64'(ch_update), (i == 6) ? 64'd1 : 64'd0);
      if (i == 6) begin
        chk("pre_ch0", 64'(get_ch(0)), 64'h2_2524_2322_2120);
        chk("pre_pad", 64'(pad_err), 64'd1);
      end
    end
    frame_start = 1'b1;
    byte_in     = 8'h99;
    byte_valid  = 1'b1;
    #1;
    chk("restart_ready", 64'(byte_ready), 64'd0);
    @(negedge clk);
    frame_start = 1'b0;
    chk("restart_update", 64'(ch_update), 64'd0);
    chk("restart_pad", 64'(pad_err), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    run_frame(1, 1'b0, 1'b0, -1, 8'h00);
    chk("restart_ch0", 64'(get_ch(0)), 64'h1_5555_5555_5555);

    // Gapped valid, back to the plan pattern
    run_frame(0, 1'b1, 1'b1, -1, 8'h00);
    chk("gap_ch0", 64'(get_ch(0)), 64'h3_0123_4567_89AB);
    chk("gap_ch7", 64'(get_ch(7)), 64'h2_1717_1717_1717);

    // Pad error on channel 3; sticky until next frame_start
    run_frame(0, 1'b0, 1'b1, 3, 8'hFE);
    chk("pad_ch3_top", 64'(get_ch(3) >> 48), 64'h2);
    chk("pad_sticky", 64'(pad_err), 64'd1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("pad_clear", 64'(pad_err), 64'd0);

    // Async reset after 30 bytes of a new frame (already in COLLECT)
    for (int i = 0; i < 30; i++) begin
      byte_in    = get_byte(1, i / 7, i % 7, -1, 8'h00);
      byte_valid = 1'b1;
      @(negedge clk);
    end
    chk("pre_rst_ch3", 64'(get_ch(3)), 64'h1_5555_5555_5555);
    #2 rst = 1'b1;
    #1;
    chk("arst_ch_out", 64'(|ch_out), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(byte_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_ch_out", 64'(|ch_out), 64'd0);
      chk("post_rst_update", 64'(ch_update), 64'd0);
    end
    byte_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mixed_to_analog_assembler.md
Name: mixed_to_analog_assembler

Overview:
- Reverse path of the analog-to-mixed byte splitter.
- Receives a serial stream of 8-bit bytes from the PICO/mixed-register side and rebuilds 8 channels of 50-bit analog register words.
- Each word arrives as 7 bytes, LSB byte first; the 7th byte carries only bits [49:48] in its low 2 bits.
- Rebuilt words drive the analog register bank; a frame-done pulse tells the control logic that all channels are loaded.

Parameters:
- WORD_W, 50, width of one channel word.
- NUM_CH, 8, number of channels per frame.
- BYTES_PER_WORD, 7, bytes per word; must equal ceil(WORD_W/8).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- frame_start  input  1  one-cycle pulse; starts or restarts a frame at channel 0, byte 0.
- byte_in  input  8  incoming data byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  block accepts a byte this cycle; equals (state==COLLECT) && !frame_start.
- ch_out  output  NUM_CH*WORD_W  assembled words; channel c occupies [c*WORD_W +: WORD_W].
- ch_update  output  NUM_CH  one-cycle pulse on bit c when channel c's word is committed.
- frame_done  output  1  one-cycle pulse after the last channel is committed.
- busy  output  1  high in COLLECT and DONE.
- pad_err  output  1  sticky; a 7th byte had nonzero bits [7:2].

Behaviour:
- Reset values: ch_out=0, ch_update=0, frame_done=0, busy=0, pad_err=0, byte_ready=0, state=IDLE, byte_idx=0, ch_idx=0, shadow=0.
- Accept condition: byte_valid && byte_ready. A byte presented while byte_ready=0 is ignored, not queued.
- FSM states: IDLE, COLLECT, DONE.
- IDLE: byte_ready=0. On frame_start go to COLLECT, clear byte_idx, ch_idx and pad_err.
- COLLECT, normal accept, byte_idx < 6: shadow[8*byte_idx +: 8] <= byte_in; byte_idx++.
- COLLECT, accept with byte_idx == 6:
  - On the next edge, ch_out[ch_idx] <= {byte_in[1:0], shadow[47:0]}.
  - ch_update[ch_idx] pulses in the same cycle the new value is visible, i.e. 1 cycle after the accept edge.
  - If byte_in[7:2] != 0, set pad_err; those bits are discarded.
  - byte_idx returns to 0 and shadow clears.
  - If ch_idx == NUM_CH-1, go to DONE; otherwise ch_idx++.
- DONE: lasts exactly 1 cycle with frame_done=1 and byte_ready=0, then returns to IDLE. ch_update for the last channel and frame_done assert in the same cycle.
- frame_start in COLLECT (abort/restart):
  - The partial word is discarded; shadow clears, byte_idx=0, ch_idx=0, pad_err clears.
  - State stays COLLECT.
  - Channels already committed keep their new values.
  - Any byte presented that cycle is not accepted, because byte_ready is forced low.
- frame_start in DONE: go directly to COLLECT with cleared counters. frame_done still pulses that cycle.
- ch_out holds its value across frames and in IDLE; only a commit or rst changes it.
- Throughput: 1 byte/cycle while in COLLECT; a full frame takes 56 accepted bytes.
- Async rst mid-frame: everything returns to reset values immediately; no commit of a partial word.

Test Plan:
- Single frame, back-to-back:
  - Stimulus: frame_start, then 56 bytes with byte_valid held high. Channel 0 bytes are AB,89,67,45,23,01,03; channel c (c>0) bytes are all 8'h(10+c) with byte 6 = 02.
  - Required: ch0 = 50'h3_0123_4567_89AB; ch1 = 50'h2_1111_1111_1111.
  - Required: ch_update bit pulses at byte accepts 7, 14, ..., 56 (+1 cycle); frame_done 1 cycle after the 56th accept; pad_err = 0.
- Gapped valid:
  - Stimulus: same data with byte_valid toggling 1/0 every cycle.
  - Required: identical ch_out; frame_done after 111 cycles from the first valid.
- Pad error:
  - Stimulus: channel 3 byte 6 = 8'hFE.
  - Required: ch3[49:48] = 2'b10; pad_err = 1 after that accept and stays set until the next frame_start.
- Mid-frame restart:
  - Stimulus: frame_start after 10 bytes, then a full 56-byte frame of 8'h55 (byte 6 = 01).
  - Required: ch0 = 50'h1_5555_5555_5555 (the pre-restart ch0 committed after byte 7 is overwritten); no ch_update for partial channel 1 before the restart; a byte offered in the frame_start cycle is dropped.
- Async reset mid-frame:
  - Stimulus: rst after 30 bytes, asserted between edges.
  - Required: ch_out = 0 and busy = 0 immediately; the following bytes are ignored until frame_start.
- Idle bytes:
  - Stimulus: byte_valid = 1 in IDLE.
  - Required: byte_ready = 0, no state or output change.
